// File: rtl/mul_final_add_pkg.sv
// Shared multiplier constants: datapath geometry and the Booth correction-bit
// mapping used by the Booth generator, compressor array and final adder.
package mul_final_add_pkg;

    localparam int MFA_WIDTH = 64;
    localparam int MFA_SPLIT = 32;
    localparam int MFA_TAG_W = 5;

    // Booth partial-product rows whose negate bits are left over after compression
    localparam int BOOTH_NEG_ROW_B0  = 0;
    localparam int BOOTH_NEG_ROW_CIN = 1;

endpackage

// File: rtl/mul_add_half.sv
// N-bit ripple adder with carry-in; one instance per pipeline stage.
module mul_add_half #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/mul_final_add.sv
// Two-stage carry-propagate adder closing the Booth/Wallace multiplier:
// low half summed in stage 1, high half in stage 2 using the registered carry.
module mul_final_add
    import mul_final_add_pkg::*;
#(
    parameter int WIDTH = MFA_WIDTH,
    parameter int SPLIT = MFA_SPLIT,
    parameter int TAG_W = MFA_TAG_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_s,
    input  logic [WIDTH-1:0] in_c,
    input  logic             in_b0,
    input  logic             in_cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int HI_W = WIDTH - SPLIT;

    logic             s1_valid_q, s1_valid_d;
    logic [SPLIT-1:0] lo_sum_q;
    logic             c_mid_q;
    logic [HI_W-1:0]  s_hi_q;
    logic [HI_W-1:0]  c_hi_q;
    logic [TAG_W-1:0] s1_tag_q;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] result_q;
    logic [TAG_W-1:0] tag_q;

    logic             s2_ready;
    logic             accept;
    logic             advance;
    logic [WIDTH-1:0] c_vec;
    logic [SPLIT-1:0] lo_sum_d;
    logic             c_mid_d;
    logic [HI_W-1:0]  hi_sum;
    logic             hi_cout;
    logic             unused_bits;

    // Column WIDTH-1 carry would land beyond the product, so it is shifted out
    assign c_vec = {in_c[WIDTH-2:0], in_b0};
    assign unused_bits = in_c[WIDTH-1] ^ hi_cout;

    assign s2_ready = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign advance  = s1_valid_q && s2_ready;

    mul_add_half #(.N(SPLIT)) u_lo_add (
        .a    (in_s[SPLIT-1:0]),
        .b    (c_vec[SPLIT-1:0]),
        .cin  (in_cin),
        .sum  (lo_sum_d),
        .cout (c_mid_d)
    );

    mul_add_half #(.N(HI_W)) u_hi_add (
        .a    (s_hi_q),
        .b    (c_hi_q),
        .cin  (c_mid_q),
        .sum  (hi_sum),
        .cout (hi_cout)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (accept)
                s1_valid_d = 1'b1;
            else if (advance)
                s1_valid_d = 1'b0;
            if (advance)
                s2_valid_d = 1'b1;
            else if (out_ready)
                s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            lo_sum_q   <= '0;
            c_mid_q    <= 1'b0;
            s_hi_q     <= '0;
            c_hi_q     <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            tag_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (accept) begin
                lo_sum_q <= lo_sum_d;
                c_mid_q  <= c_mid_d;
                s_hi_q   <= in_s[WIDTH-1:SPLIT];
                c_hi_q   <= c_vec[WIDTH-1:SPLIT];
                s1_tag_q <= in_tag;
            end
            if (advance) begin
                result_q <= {hi_sum, lo_sum_q};
                tag_q    <= s1_tag_q;
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = result_q;
    assign out_tag    = tag_q;

endmodule

// File: tb/tb_mul_final_add.sv
// Directed and randomized checks of mul_final_add against an arithmetic
// reference and a transaction queue.
module tb_mul_final_add;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_s = '0;
    logic [63:0] in_c = '0;
    logic        in_b0 = 1'b0;
    logic        in_cin = 1'b0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_result;
    logic [4:0]  out_tag;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [68:0] exp_q[$];

    mul_final_add dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_s       (in_s),
        .in_c       (in_c),
        .in_b0      (in_b0),
        .in_cin     (in_cin),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    // Product as the multiplier defines it: sum vector plus the carry vector
    // weighted one column up, plus both correction bits, modulo 2^64.
    function automatic logic [63:0] ref_sum(input logic [63:0] s, input logic [63:0] c,
                                            input logic b0, input logic cin);
        longint unsigned acc;
        acc = longint'(s) + (longint'(c) << 1) + longint'(b0) + longint'(cin);
        return acc;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
            $display("check %-18s obs=%h exp=%h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] s, input logic [63:0] c,
                         input logic b0, input logic cin, input logic [4:0] tag);
        in_valid = v;
        in_s     = s;
        in_c     = c;
        in_b0    = b0;
        in_cin   = cin;
        in_tag   = tag;
    endtask

    initial begin
        logic [63:0] r_s, r_c, exp_r;
        logic        r_b0, r_cin, exp_rdy;
        logic [4:0]  r_tag;
        logic [68:0] front;
        logic [63:0] res_a, res_b;

        // ---------------- reset state ----------------
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_tag", {59'd0, out_tag}, 64'd0);
        step();
        step();
        resetn = 1'b1;
        step();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // ---------------- carry across the split ----------------
        drive(1'b1, 64'h0000_0000_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 5'd7);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 5'd0);
        chk("split_lat1_valid", {63'd0, out_valid}, 64'd0);
        step();
        chk("split_valid", {63'd0, out_valid}, 64'd1);
        chk("split_result", out_result, 64'h0000_0001_0000_0000);
        chk("split_tag", {59'd0, out_tag}, 64'd7);
        step();
        chk("split_drained", {63'd0, out_valid}, 64'd0);

        // ---------------- full wrap ----------------
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 5'd9);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 5'd0);
        step();
        chk("wrap_valid", {63'd0, out_valid}, 64'd1);
        chk("wrap_result", out_result, 64'd0);
        step();

        // ---------------- back-to-back ----------------
        res_a = ref_sum(64'd100, 64'd5, 1'b1, 1'b0);
        res_b = ref_sum(64'd200, 64'd6, 1'b0, 1'b1);
        drive(1'b1, 64'd100, 64'd5, 1'b1, 1'b0, 5'd1);
        #1 chk("b2b_rdy1", {63'd0, in_ready}, 64'd1);
        step();
        drive(1'b1, 64'd200, 64'd6, 1'b0, 1'b1, 5'd2);
        #1 chk("b2b_rdy2", {63'd0, in_ready}, 64'd1);
        chk("b2b_empty", {63'd0, out_valid}, 64'd0);
        step();
        drive(1'b1, 64'd300, 64'd7, 1'b1, 1'b1, 5'd3);
        #1 chk("b2b_rdy3", {63'd0, in_ready}, 64'd1);
        chk("b2b_res1", out_result, res_a);
        chk("b2b_tag1", {59'd0, out_tag}, 64'd1);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 5'd0);
        #1 chk("b2b_res2", out_result, res_b);
        chk("b2b_tag2", {59'd0, out_tag}, 64'd2);
        step();
        chk("b2b_res3", out_result, ref_sum(64'd300, 64'd7, 1'b1, 1'b1));
        chk("b2b_tag3", {59'd0, out_tag}, 64'd3);
        step();
        chk("b2b_done", {63'd0, out_valid}, 64'd0);

        // ---------------- stall ----------------
        res_a = ref_sum(64'hDEAD_BEEF_0000_1111, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
        res_b = ref_sum(64'h1111_2222_3333_4444, 64'hF0F0_F0F0_F0F0_F0F0, 1'b1, 1'b1);
        out_ready = 1'b0;
        drive(1'b1, 64'hDEAD_BEEF_0000_1111, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, 5'd10);
        step();
        drive(1'b1, 64'h1111_2222_3333_4444, 64'hF0F0_F0F0_F0F0_F0F0, 1'b1, 1'b1, 5'd11);
        #1 chk("stall_rdy_half", {63'd0, in_ready}, 64'd1);
        step();
        drive(1'b1, 64'h5555_5555_5555_5555, 64'd1, 1'b1, 1'b1, 5'd12);
        #1 chk("stall_rdy_full", {63'd0, in_ready}, 64'd0);
        chk("stall_res_a", out_result, res_a);
        step();
        step();
        chk("stall_hold_rdy", {63'd0, in_ready}, 64'd0);
        chk("stall_hold_res", out_result, res_a);
        chk("stall_hold_tag", {59'd0, out_tag}, 64'd10);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1 chk("stall_rdy_back", {63'd0, in_ready}, 64'd1);
        step();
        chk("stall_res_b", out_result, res_b);
        chk("stall_tag_b", {59'd0, out_tag}, 64'd11);
        step();
        chk("stall_no_third", {63'd0, out_valid}, 64'd0);

        // ---------------- flush ----------------
        out_ready = 1'b0;
        drive(1'b1, 64'd1, 64'd1, 1'b0, 1'b0, 5'd20);
        step();
        drive(1'b1, 64'd2, 64'd2, 1'b0, 1'b0, 5'd21);
        step();
        drive(1'b1, 64'd3, 64'd3, 1'b0, 1'b0, 5'd22);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1 chk("flush_ov_next", {63'd0, out_valid}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_ov_later", {63'd0, out_valid}, 64'd0);
        end

        // ---------------- reset mid-operation ----------------
        out_ready = 1'b0;
        drive(1'b1, 64'hAAAA_0000_BBBB_0000, 64'h1234, 1'b1, 1'b0, 5'd25);
        step();
        in_valid = 1'b0;
        step();
        chk("mid_pre_valid", {63'd0, out_valid}, 64'd1);
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_result", out_result, 64'd0);
        chk("mid_rst_tag", {59'd0, out_tag}, 64'd0);
        step();
        resetn = 1'b1;
        out_ready = 1'b1;
        #1 chk("mid_rdy_after", {63'd0, in_ready}, 64'd1);
        step();
        drive(1'b1, 64'hFFFF_FFFF_0000_0001, 64'h7FFF_FFFF_8000_0000, 1'b1, 1'b1, 5'd26);
        step();
        in_valid = 1'b0;
        step();
        chk("mid_after_valid", {63'd0, out_valid}, 64'd1);
        chk("mid_after_res", out_result,
            ref_sum(64'hFFFF_FFFF_0000_0001, 64'h7FFF_FFFF_8000_0000, 1'b1, 1'b1));
        chk("mid_after_tag", {59'd0, out_tag}, 64'd26);
        step();

        // ---------------- randomized traffic ----------------
        exp_q.delete();
        for (int cyc = 0; cyc < 300; cyc++) begin
            r_s   = {$urandom, $urandom};
            r_c   = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) r_s = '1;
            if ($urandom_range(0, 7) == 0) r_c = '1;
            r_b0  = 1'($urandom_range(0, 1));
            r_cin = 1'($urandom_range(0, 1));
            r_tag = 5'($urandom);
            drive(1'($urandom_range(0, 1)), r_s, r_c, r_b0, r_cin, r_tag);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = (exp_q.size() < 2) || out_ready;
            chk("rnd_in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
            if (out_valid && exp_q.size() == 0) begin
                chk("rnd_spurious_ov", 64'd1, 64'd0);
            end else if (out_valid && out_ready) begin
                front = exp_q.pop_front();
                chk("rnd_result", out_result, front[63:0]);
                chk("rnd_tag", {59'd0, out_tag}, {59'd0, front[68:64]});
            end
            if (in_valid && exp_rdy) begin
                exp_r = ref_sum(r_s, r_c, r_b0, r_cin);
                exp_q.push_back({r_tag, exp_r});
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            #1;
            if (out_valid) begin
                front = exp_q.pop_front();
                chk("drain_result", out_result, front[63:0]);
                chk("drain_tag", {59'd0, out_tag}, {59'd0, front[68:64]});
            end
            step();
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
